fft_frame_scheduler: RTL and testbench
======================================

// Module: fft_frame_scheduler
// PURPOSE
//  Frame-granular round-robin scheduler that shares a single fft_core between NUM_REQ requester streams.
//  Grants whole frames of FRAME_LEN samples, forwards them to the core and tags each frame in order.
//  Routes the core's output frames back to the originating requester.
//  Sits between requester sources/sinks and fft_core; the core is unmodified.
// PARAMETERS
//  DATA_WIDTH  50  sample width; packed {re[DATA_WIDTH/2-1:0], im[DATA_WIDTH/2-1:0]}, passed through untouched
//  NUM_REQ     2   number of requesters, 2..4
//  FRAME_LEN   8   samples per FFT frame, power of 2, >=2
//  TAG_DEPTH   4   max frames in flight inside the core (tag FIFO depth), power of 2
// PORTS
//  clk_i          in   1                   clock, rising edge
//  rst_i          in   1                   synchronous reset, active high
//  req_signal_i   in   NUM_REQ*DATA_WIDTH  requester samples, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//  req_valid_i    in   NUM_REQ             requester sample valid
//  req_ready_o    out  NUM_REQ             requester sample accepted when valid&ready
//  core_signal_o  out  DATA_WIDTH          to fft_core signal_i
//  core_valid_o   out  1                   to fft_core valid_i
//  core_ready_i   in   1                   from fft_core ready_o
//  core_signal_i  in   DATA_WIDTH          from fft_core signal_o
//  core_valid_i   in   1                   from fft_core valid_o
//  core_ready_o   out  1                   to fft_core ready_i
//  rsp_signal_o   out  DATA_WIDTH          result sample, shared by all requesters
//  rsp_valid_o    out  NUM_REQ             one-hot result valid, destination requester
//  rsp_ready_i    in   NUM_REQ             requester result ready
//  grant_o        out  $clog2(NUM_REQ)     requester currently loading; valid while busy_o
//  busy_o         out  1                   1 in LOAD state
//  err_o          out  1                   sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all registers clear, FSM=IDLE, rr_ptr=0, tag FIFO empty, counters 0.
//   Outputs: req_ready_o=0, core_valid_o=0, core_ready_o=0, rsp_valid_o=0, grant_o=0, busy_o=0, err_o=0.
//  Reset mid-frame discards in-flight tags and partial counts; no further output is routed until new grants.
//  Input side FSM:
//   IDLE: searches req_valid_i round-robin starting at rr_ptr.
//    If any is valid and the tag FIFO is not full: register grant, push grant into tag FIFO, move to LOAD.
//    Otherwise stay in IDLE. This costs exactly one bubble cycle per frame.
//   LOAD: pure combinational pass-through, zero latency.
//    core_signal_o=req_signal_i[grant]; core_valid_o=req_valid_i[grant]; req_ready_o[grant]=core_ready_i.
//    All other req_ready_o bits are 0.
//    in_cnt increments on each core_valid_o&core_ready_i.
//    On the FRAME_LEN-th transfer: in_cnt=0, rr_ptr=grant+1 (mod NUM_REQ), next state IDLE.
//   A grant is locked for the whole frame; the granted requester may drop valid mid-frame. This stalls with no timeout.
//  Output side (independent of FSM, runs concurrently):
//   Destination dest = tag FIFO head.
//   FIFO non-empty: rsp_signal_o=core_signal_i; rsp_valid_o=core_valid_i<<dest; core_ready_o=rsp_ready_i[dest].
//   FIFO empty: rsp_valid_o=0 and core_ready_o=0 (core output is held).
//   out_cnt increments per core_valid_i&core_ready_o; on the FRAME_LEN-th transfer, pop the tag and set out_cnt=0.
//  Simultaneous push (grant) and pop (frame done) in one cycle: FIFO occupancy is unchanged, and both take effect.
//  A full FIFO blocks new grants only; the output side keeps draining.
//  rr_ptr wraps NUM_REQ-1 -> 0; tag FIFO pointers wrap modulo TAG_DEPTH.
// CONFIGURATION
//  FFT_SCHED_ERR_EN defined:
//   err_o sets when core_valid_i=1 while the tag FIFO is empty.
//   err_o also sets when req_valid_i is seen on the granted port in IDLE the cycle after a frame-end.
//    This flags a requester exceeding FRAME_LEN samples, and it is advisory only.
//   err_o stays set until rst_i.
//  FFT_SCHED_ERR_EN undefined: err_o tied to 0, no checking logic is built.
// TESTING (DATA_WIDTH=50, NUM_REQ=2, FRAME_LEN=8, TAG_DEPTH=4, fft_core attached or modelled)
//  1. After reset, req_valid_i=2'b01 with 8 samples from req0.
//     -> grant_o=0; busy_o for exactly 8 accepted beats.
//     -> 8 results on rsp_valid_o=2'b01, bit-equal to the core driven directly. First result 50'h000090a0001e0.
//  2. Both requesters valid continuously for 4 frames.
//     -> grants alternate 0,1,0,1; one IDLE cycle between frames.
//     -> results return in the same order, rsp_valid_o 01,10,01,10.
//  3. core_ready_i=0 for 3 cycles mid-frame.
//     -> req_ready_o[grant]=0 for those cycles; no sample is lost or duplicated; in_cnt ends at 8.
//  4. rsp_ready_i tied 0, 5 frames offered.
//     -> exactly 4 grants issued; FSM stays in IDLE with busy_o=0.
//     -> After rsp_ready_i=1 the 4 frames drain, then the 5th frame is granted.
//  5. Assert rst_i after 3 samples of a frame.
//     -> next cycle req_ready_o=0, rsp_valid_o=0, busy_o=0.
//     -> A fresh frame from req1 is granted first (rr_ptr=0, only req1 valid) and is routed correctly.
//  6. With FFT_SCHED_ERR_EN, drive core_valid_i=1 with the FIFO empty.
//     -> err_o=1 next cycle and holds. Without the macro, err_o stays 0.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// Frame-granular round-robin scheduler sharing one fft_core among NUM_REQ requester streams.
// Optional sticky protocol checker enabled by defining FFT_SCHED_ERR_EN.
module fft_frame_scheduler #(
    parameter int unsigned DATA_WIDTH = 50,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FRAME_LEN  = 8,
    parameter int unsigned TAG_DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_signal_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         core_signal_o,
    output logic                          core_valid_o,
    input  logic                          core_ready_i,
    input  logic [DATA_WIDTH-1:0]         core_signal_i,
    input  logic                          core_valid_i,
    output logic                          core_ready_o,
    output logic [DATA_WIDTH-1:0]         rsp_signal_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_o,
    output logic                          busy_o,
    output logic                          err_o
);
    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(FRAME_LEN);
    localparam int unsigned TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned OW = TW + 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, rr_ptr, sel, dest;
    logic [CW-1:0]   in_cnt, out_cnt;
    logic [TW-1:0]   wr_ptr, rd_ptr;
    logic [OW-1:0]   occ;
    logic [GW-1:0]   tag_mem [TAG_DEPTH];
    logic            found, full, empty;
    logic            push, pop, in_xfer, out_xfer, frame_end;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

    function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
        return (p == TW'(TAG_DEPTH - 1)) ? '0 : p + TW'(1);
    endfunction

    assign full    = (occ == OW'(TAG_DEPTH));
    assign empty   = (occ == '0);
    assign dest    = tag_mem[rd_ptr];
    assign grant_o = grant;
    assign busy_o  = (state == LOAD);

    // Round-robin pick: descending offsets so the nearest valid requester to rr_ptr wins.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[rr_idx(rr_ptr, 32'(i))]) begin
                sel   = rr_idx(rr_ptr, 32'(i));
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Input-side next state and zero-latency pass-through while loading.
    always_comb begin
        state_nxt     = state;
        push          = 1'b0;
        in_xfer       = 1'b0;
        frame_end     = 1'b0;
        req_ready_o   = '0;
        core_valid_o  = 1'b0;
        core_signal_o = req_signal_i[32'(grant) * DATA_WIDTH +: DATA_WIDTH];
        case (state)
            IDLE: begin
                if (found && !full) begin
                    push      = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                core_valid_o       = req_valid_i[grant];
                req_ready_o[grant] = core_ready_i;
                if (req_valid_i[grant] && core_ready_i) begin
                    in_xfer = 1'b1;
                    if (in_cnt == CW'(FRAME_LEN - 1)) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output side routes core results to the tag at the FIFO head.
    always_comb begin
        rsp_signal_o = core_signal_i;
        rsp_valid_o  = '0;
        core_ready_o = 1'b0;
        out_xfer     = 1'b0;
        pop          = 1'b0;
        if (!empty) begin
            rsp_valid_o[dest] = core_valid_i;
            core_ready_o      = rsp_ready_i[dest];
            if (core_valid_i && rsp_ready_i[dest]) begin
                out_xfer = 1'b1;
                pop      = (out_cnt == CW'(FRAME_LEN - 1));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant   <= '0;
            rr_ptr  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
        end else begin
            if (push) begin
                grant           <= sel;
                tag_mem[wr_ptr] <= sel;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (in_xfer) in_cnt <= frame_end ? '0 : in_cnt + CW'(1);
            if (frame_end) rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
            if (out_xfer) out_cnt <= pop ? '0 : out_cnt + CW'(1);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef FFT_SCHED_ERR_EN
    logic frame_end_q, err_q;

    // Sticky: core output with no tag, or granted requester still pushing right after its frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_end_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            frame_end_q <= frame_end;
            if ((core_valid_i && empty) ||
                (frame_end_q && state == IDLE && req_valid_i[grant]))
                err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler with a modelled fft_core (FIFO plus XOR transform).
`timescale 1ns/1ps
module tb_fft_frame_scheduler;
    localparam int unsigned DW = 50;
    localparam int unsigned NR = 2;
    localparam int unsigned FL = 8;
    localparam int unsigned TD = 4;
    localparam logic [DW-1:0] MASK = 50'h2_AAAA_5555_F00F;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic [NR*DW-1:0] req_signal_i = '0;
    logic [NR-1:0]    req_valid_i = '0;
    logic [NR-1:0]    req_ready_o;
    logic [DW-1:0]    core_signal_o;
    logic             core_valid_o;
    logic             core_ready_i = 1'b0;
    logic [DW-1:0]    core_signal_i = '0;
    logic             core_valid_i = 1'b0;
    logic             core_ready_o;
    logic [DW-1:0]    rsp_signal_o;
    logic [NR-1:0]    rsp_valid_o;
    logic [NR-1:0]    rsp_ready_i = '0;
    logic [0:0]       grant_o;
    logic             busy_o;
    logic             err_o;

    always #5 clk = ~clk;

    fft_frame_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FRAME_LEN(FL), .TAG_DEPTH(TD)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_signal_i(req_signal_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .core_signal_o(core_signal_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_signal_i(core_signal_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
        .rsp_signal_o(rsp_signal_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
    );

    // Sequencer-owned knobs
    int target [NR];
    int valid_pct = 100, core_rdy_pct = 100, rsp_rdy_pct = 100, cvalid_pct = 100;
    bit core_stall = 0, rsp_hold = 0, force_cvalid = 0;

    // Stimulus/core-model state
    int            sent [NR];
    logic [DW-1:0] pend [NR];
    bit            has_pend [NR];
    logic [DW-1:0] core_q [$];
    bit            cpresent = 0;

    // Scoreboard and monitor logs
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int grant_log [$];
    int gap_log [$];
    int dest_log [$];
    int rsp_cnt [NR];
    int n_checks = 0, n_fail = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requesters and core model: sample handshakes mid-cycle, drive just after the edge.
    always begin
        @(negedge clk);
        if (rst_i) begin
            core_q.delete();
            exp_q0.delete();
            exp_q1.delete();
            cpresent = 0;
            for (int k = 0; k < NR; k++) has_pend[k] = 0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (req_valid_i[k] && req_ready_o[k]) begin
                    if (k == 0) exp_q0.push_back(pend[k] ^ MASK);
                    else        exp_q1.push_back(pend[k] ^ MASK);
                    has_pend[k] = 0;
                    sent[k]++;
                end
            end
            if (core_valid_o && core_ready_i) core_q.push_back(core_signal_o ^ MASK);
            if (cpresent && core_valid_i && core_ready_o) begin
                void'(core_q.pop_front());
                cpresent = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (!has_pend[k] && sent[k] < target[k]) begin
                pend[k]     = {2'(k), 16'(sent[k]), 32'($urandom)};
                has_pend[k] = 1;
            end
            req_valid_i[k] = has_pend[k] && (sent[k] < target[k]) && ($urandom_range(99) < valid_pct);
            req_signal_i[k*DW +: DW] = pend[k];
            rsp_ready_i[k] = !rsp_hold && ($urandom_range(99) < rsp_rdy_pct);
        end
        core_ready_i = !core_stall && ($urandom_range(99) < core_rdy_pct);
        if (!cpresent && core_q.size() > 0 && $urandom_range(99) < cvalid_pct) cpresent = 1;
        core_valid_i  = cpresent || force_cvalid;
        core_signal_i = cpresent ? core_q[0] : '0;
    end

    // Monitor: scoreboard pops, frame integrity and grant/route logging.
    bit busy_prev = 0;
    int beats = 0, out_beats = 0, idle_run = 0;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_i) begin
            busy_prev = 0;
            beats     = 0;
            out_beats = 0;
            idle_run  = 0;
        end else begin
            if (rsp_valid_o != '0)
                check($onehot0(rsp_valid_o), "rsp_valid_onehot", 64'(rsp_valid_o), 64'(0));
            for (int k = 0; k < NR; k++) begin
                if (rsp_valid_o[k] && rsp_ready_i[k]) begin
                    if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        check(0, "rsp_unexpected", 64'(rsp_signal_o), 64'(k));
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check(rsp_signal_o == e, "rsp_data", 64'(rsp_signal_o), 64'(e));
                    end
                    rsp_cnt[k]++;
                    out_beats++;
                    if (out_beats == FL) begin
                        dest_log.push_back(k);
                        out_beats = 0;
                    end
                end
            end
            if (req_ready_o != '0)
                check(busy_o && req_ready_o == (2'(1) << grant_o), "req_ready_grant",
                      64'(req_ready_o), 64'(2'(1) << grant_o));
            if (busy_o && !busy_prev) begin
                grant_log.push_back(int'(grant_o));
                gap_log.push_back(idle_run);
                beats = 0;
            end
            if (busy_o && (req_valid_i & req_ready_o) != '0) beats++;
            if (!busy_o && busy_prev) check(beats == FL, "frame_beats", 64'(beats), 64'(FL));
            idle_run  = busy_o ? 0 : idle_run + 1;
            busy_prev = busy_o;
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (n < budget && !(sent[0] == target[0] && sent[1] == target[1] &&
                   exp_q0.size() == 0 && exp_q1.size() == 0 && core_q.size() == 0 && !busy_o));
        check(n < budget, name, 64'(n), 64'(budget));
    endtask

    task automatic wait_sent(input int k, input int val);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (sent[k] < val && n < 500);
        check(sent[k] >= val, "wait_sent", 64'(sent[k]), 64'(val));
    endtask

    task automatic do_reset();
        for (int k = 0; k < NR; k++) target[k] = sent[k];
        @(posedge clk);
        #2;
        rst_i = 1;
        @(posedge clk);
        #2;
        rst_i = 0;
    endtask

    initial begin
        int g0, d0, r0, r1, s0;
        for (int k = 0; k < NR; k++) begin
            target[k] = 0; sent[k] = 0; has_pend[k] = 0; rsp_cnt[k] = 0; pend[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(req_ready_o == '0, "rst_req_ready", 64'(req_ready_o), 0);
        check(core_valid_o == 0, "rst_core_valid", 64'(core_valid_o), 0);
        check(core_ready_o == 0, "rst_core_ready", 64'(core_ready_o), 0);
        check(rsp_valid_o == '0, "rst_rsp_valid", 64'(rsp_valid_o), 0);
        check(grant_o == '0, "rst_grant", 64'(grant_o), 0);
        check(busy_o == 0, "rst_busy", 64'(busy_o), 0);
        check(err_o == 0, "rst_err", 64'(err_o), 0);
        @(posedge clk);
        #2;
        rst_i = 0;

        // Single frame from req0
        g0 = grant_log.size(); r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
        target[0] += FL;
        wait_idle(2000, "t1_timeout");
        check(grant_log.size() == g0 + 1, "t1_grants", 64'(grant_log.size() - g0), 1);
        if (grant_log.size() > g0) check(grant_log[g0] == 0, "t1_grant", 64'(grant_log[g0]), 0);
        check(rsp_cnt[0] == r0 + FL, "t1_rsp0", 64'(rsp_cnt[0] - r0), 64'(FL));
        check(rsp_cnt[1] == r1, "t1_rsp1", 64'(rsp_cnt[1] - r1), 0);

        // Both requesters continuous for 4 frames, from a fresh rr_ptr
        do_reset();
        g0 = grant_log.size(); d0 = dest_log.size();
        target[0] += 2 * FL; target[1] += 2 * FL;
        wait_idle(2000, "t2_timeout");
        check(grant_log.size() == g0 + 4, "t2_grants", 64'(grant_log.size() - g0), 4);
        check(dest_log.size() == d0 + 4, "t2_frames", 64'(dest_log.size() - d0), 4);
        for (int i = 0; i < 4; i++) begin
            if (grant_log.size() > g0 + i)
                check(grant_log[g0+i] == i % 2, "t2_grant_order", 64'(grant_log[g0+i]), 64'(i % 2));
            if (dest_log.size() > d0 + i)
                check(dest_log[d0+i] == i % 2, "t2_rsp_order", 64'(dest_log[d0+i]), 64'(i % 2));
            if (i > 0 && gap_log.size() > g0 + i)
                check(gap_log[g0+i] == 1, "t2_idle_gap", 64'(gap_log[g0+i]), 1);
        end

        // Core stalls for 3 cycles mid-frame
        s0 = sent[0];
        target[0] += FL;
        wait_sent(0, s0 + 3);
        core_stall = 1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check(req_ready_o == '0 && busy_o, "t3_stall_ready", 64'(req_ready_o), 0);
        end
        core_stall = 0;
        wait_idle(2000, "t3_timeout");

        // Responses blocked: tag FIFO fills after TAG_DEPTH grants
        rsp_hold = 1;
        g0 = grant_log.size();
        target[0] += 3 * FL; target[1] += 2 * FL;
        repeat (300) @(posedge clk);
        #2;
        check(grant_log.size() == g0 + TD, "t4_grants_full", 64'(grant_log.size() - g0), 64'(TD));
        check(busy_o == 0, "t4_busy", 64'(busy_o), 0);
        rsp_hold = 0;
        wait_idle(3000, "t4_timeout");
        check(grant_log.size() == g0 + 5, "t4_grants_drain", 64'(grant_log.size() - g0), 5);

        // Randomized traffic
        for (int r = 0; r < 4; r++) begin
            valid_pct    = $urandom_range(100, 30);
            core_rdy_pct = $urandom_range(100, 30);
            rsp_rdy_pct  = $urandom_range(100, 30);
            cvalid_pct   = $urandom_range(100, 30);
            target[0] += FL * $urandom_range(4, 1);
            target[1] += FL * $urandom_range(4, 1);
            wait_idle(6000, "rand_timeout");
        end
        valid_pct = 100; core_rdy_pct = 100; rsp_rdy_pct = 100; cvalid_pct = 100;

        // Reset mid-frame, then a fresh frame from req1
        s0 = sent[0];
        target[0] += FL;
        wait_sent(0, s0 + 3);
        target[0] = sent[0];
        rst_i = 1;
        @(posedge clk);
        #2;
        rst_i = 0;
        @(negedge clk);
        check(req_ready_o == '0, "t5_req_ready", 64'(req_ready_o), 0);
        check(rsp_valid_o == '0, "t5_rsp_valid", 64'(rsp_valid_o), 0);
        check(busy_o == 0, "t5_busy", 64'(busy_o), 0);
        g0 = grant_log.size(); r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
        target[1] += FL;
        wait_idle(2000, "t5_timeout");
        check(grant_log.size() == g0 + 1, "t5_grants", 64'(grant_log.size() - g0), 1);
        if (grant_log.size() > g0) check(grant_log[g0] == 1, "t5_grant", 64'(grant_log[g0]), 1);
        check(rsp_cnt[1] == r1 + FL, "t5_rsp1", 64'(rsp_cnt[1] - r1), 64'(FL));
        check(rsp_cnt[0] == r0, "t5_rsp0", 64'(rsp_cnt[0] - r0), 0);

        // Core output with an empty tag FIFO
        do_reset();
        @(negedge clk);
        check(err_o == 0, "t6_err_clear", 64'(err_o), 0);
        @(posedge clk);
        #2;
        force_cvalid = 1;
        repeat (2) @(posedge clk);
        #2;
        force_cvalid = 0;
        check(rsp_valid_o == '0, "t6_no_route", 64'(rsp_valid_o), 0);
        repeat (3) begin
            @(negedge clk);
`ifdef FFT_SCHED_ERR_EN
            check(err_o == 1, "t6_err_set", 64'(err_o), 1);
`else
            check(err_o == 0, "t6_err_tied", 64'(err_o), 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
